aes_encrypt_iter: RTL and testbench

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_encrypt_iter.sv | 117 +++++++++++
 tb/tb_aes_encrypt_iter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES block encryptor, one round per clock
// Round keys are read straight from the caller's expanded schedule; w must stay stable while busy.
module aes_encrypt_iter #(
  parameter int nr = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [0:127]             in,
  input  logic [0:128*(nr+1)-1]    w,
  output logic [0:127]             out,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  // Forward S-box, entry x at bits [8x +: 8]
  localparam logic [0:2047] sbox_table = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t         fsm;
  logic [3:0]   rnd;
  logic [0:127] st;
  logic [0:127] rk;
  logic [0:127] res;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic         last;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {x, 3'b000};
    return sbox_table[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] b0, b1, b2, b3;
    b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {b0, b1, b2, b3};
  endfunction

  assign last = (rnd == 4'(nr));
  assign busy = (fsm != IDLE);

  always_comb begin
    rk  = w[0 +: 128];
    res = '0;
    for (int r = 0; r <= nr; r++) begin
      if (rnd == 4'(r)) rk = w[128*r +: 128];
    end
    for (int i = 0; i < 16; i++) sb[i] = sbox(st[8*i +: 8]);
    // Byte index is row + 4*column; row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    for (int c = 0; c < 4; c++) begin
      {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
        mix_col(sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) res[8*i +: 8] = (last ? sr[i] : mc[i]) ^ rk[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm  <= IDLE;
      rnd  <= '0;
      st   <= '0;
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            st  <= in ^ w[0 +: 128];
            rnd <= 4'd1;
            fsm <= RUN;
          end
        end
        RUN: begin
          st <= res;
          if (last) begin
            out  <= res;
            done <= 1'b1;
            fsm  <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          rnd <= '0;
          fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb/tb_aes_encrypt_iter.sv - directed FIPS-197 vector bench for aes_encrypt_iter
module tb_aes_encrypt_iter;

  localparam logic [0:127] key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] pt_c   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:255] key_c3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] ct_c3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst_n, start, start14;
  logic [0:127] in, in14, out, out14;
  logic [0:1407] w;
  logic [0:1919] w14;
  logic         busy, done, busy14, done14;
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sbox_m [256];

  always #5 clk = ~clk;

  aes_encrypt_iter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .w(w),
    .out(out), .busy(busy), .done(done)
  );

  aes_encrypt_iter #(.nr(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .start(start14), .in(in14), .w(w14),
    .out(out14), .busy(busy14), .done(done14)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from the field inverse plus affine map, independent of the RTL table
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
  endfunction

  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] r;
    int            total;
    total = 4 * (nk + 7);
    rc = 8'h01;
    r = '0;
    for (int i = 0; i < 60; i++) wd[i] = 32'h0;
    for (int i = 0; i < nk; i++) wd[i] = key[32*i +: 32];
    for (int i = nk; i < total; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < total; i++) r[32*i +: 32] = wd[i];
    return r;
  endfunction

  task automatic set_key_128(input logic [0:127] key);
    logic [0:1919] tmp;
    tmp = expand({key, 128'h0}, 4);
    w = tmp[0:1407];
  endtask

  // Pulse start for one edge and count edges (accepting edge = 1) until done; -1 on timeout
  task automatic pulse_wait(input int limit, output int lat);
    lat = -1;
    start = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; start14 = 1'b0;
    in = '0; in14 = '0; w = '0; w14 = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out !== 128'h0) begin failures++; $display("FAIL reset_out: got %h expected 0", out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (out14 !== 128'h0) begin failures++; $display("FAIL reset_out14: got %h expected 0", out14); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_app_b();
    int lat;
    set_key_128(key_b);
    in = pt_b;
    pulse_wait(30, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL app_b_latency: got %0d expected 11", lat); end
    checks++; if (out !== ct_b) begin failures++; $display("FAIL app_b_out: got %h expected %h", out, ct_b); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL app_b_busy_in_done: got %b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL app_b_done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL app_b_busy_idle: got %b expected 0", busy); end
    in = pt_c;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (out !== ct_b) begin failures++; $display("FAIL app_b_out_hold: got %h expected %h", out, ct_b); end
  endtask

  task automatic test_app_c1();
    int bcnt, ndone;
    set_key_128(key_c1);
    in = pt_c;
    bcnt = 0; ndone = 0;
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bcnt++;
      if (done) ndone++;
    end
    checks++; if (bcnt !== 11) begin failures++; $display("FAIL c1_busy_cycles: got %0d expected 11", bcnt); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL c1_done_count: got %0d expected 1", ndone); end
    checks++; if (out !== ct_c1) begin failures++; $display("FAIL c1_out: got %h expected %h", out, ct_c1); end
  endtask

  task automatic test_start_held();
    int exp_k [3] = '{10, 22, 34};
    int ndone;
    set_key_128(key_b);
    in = pt_b;
    ndone = 0;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (ndone < 3) begin
          checks++;
          if (k !== exp_k[ndone]) begin
            failures++; $display("FAIL held_done_edge%0d: got %0d expected %0d", ndone, k, exp_k[ndone]);
          end
        end
        checks++; if (out !== ct_b) begin failures++; $display("FAIL held_out: got %h expected %h", out, ct_b); end
        ndone++;
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 3) begin failures++; $display("FAIL held_done_count: got %0d expected 3", ndone); end
    for (int n = 0; n < 30 && busy; n++) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_drain: busy got %b expected 0", busy); end
  endtask

  task automatic test_restart_ignored();
    int ndone, first;
    set_key_128(key_b);
    in = pt_b;
    ndone = 0; first = -1;
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start = (n == 5);
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 1) begin failures++; $display("FAIL restart_done_count: got %0d expected 1", ndone); end
    checks++; if (first !== 11) begin failures++; $display("FAIL restart_latency: got %0d expected 11", first); end
    checks++; if (out !== ct_b) begin failures++; $display("FAIL restart_out: got %h expected %h", out, ct_b); end
  endtask

  task automatic test_reset_mid();
    int ndone, lat;
    set_key_128(key_c1);
    in = pt_c;
    start = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out !== 128'h0) begin failures++; $display("FAIL midrst_out: got %h expected 0", out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL midrst_no_resume: got %0d active cycles expected 0", ndone); end
    checks++; if (out !== 128'h0) begin failures++; $display("FAIL midrst_out_after: got %h expected 0", out); end
    pulse_wait(30, lat);
    checks++; if (lat !== 11) begin failures++; $display("FAIL midrst_restart_latency: got %0d expected 11", lat); end
    checks++; if (out !== ct_c1) begin failures++; $display("FAIL midrst_restart_out: got %h expected %h", out, ct_c1); end
    @(posedge clk); #1;
  endtask

  task automatic test_nr14();
    int lat;
    w14 = expand(key_c3, 8);
    in14 = pt_c;
    lat = -1;
    start14 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start14 = 1'b0;
      if (done14) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat !== 15) begin failures++; $display("FAIL nr14_latency: got %0d expected 15", lat); end
    checks++; if (out14 !== ct_c3) begin failures++; $display("FAIL nr14_out: got %h expected %h", out14, ct_c3); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_app_b();
    test_app_c1();
    test_start_held();
    test_restart_ignored();
    test_reset_mid();
    test_nr14();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
